// File: rtl/sd_dat_block_rx_if.sv
// Signal bundle between the SD data-block receiver and its controller.
// The controller (master) drives the sample strobe, the arm request and
// the DAT lines. The receiver (slave) returns the byte stream and the
// block status.
interface sd_dat_block_rx_if;
    logic       sample;
    logic       arm;
    logic [3:0] sd_datIn;
    logic       busy;
    logic [7:0] data;
    logic       data_valid;
    logic       done;
    logic       crc_ok;
    logic       timeout;

    modport master (
        output sample, arm, sd_datIn,
        input  busy, data, data_valid, done, crc_ok, timeout
    );

    modport slave (
        input  sample, arm, sd_datIn,
        output busy, data, data_valid, done, crc_ok, timeout
    );
endinterface

// File: rtl/sd_dat_block_rx.sv
// Receives one data block on the 4-bit SD DAT bus.
// DAT is sampled on SD-clock rising-edge strobes, and each pair of nibbles is
// assembled into a byte (high nibble first). Each line's CRC16 and the end bit
// are checked, and the block ends with one done pulse carrying its status.
// A block that never starts ends in a timeout.
module sd_dat_block_rx #(
    parameter int BLOCK_BYTES     = 512,
    parameter int TIMEOUT_STROBES = 65535
) (
    input  logic            clk12mhz,
    input  logic            rst_n,
    sd_dat_block_rx_if.slave bus
);

    localparam int NIBBLES = 2 * BLOCK_BYTES;
    localparam int NW      = $clog2(NIBBLES);
    localparam int TW      = $clog2(TIMEOUT_STROBES + 1);

    localparam logic [NW-1:0] NIB_LAST = NW'(NIBBLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_STROBES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_CRC   = 3'd3;
    localparam logic [2:0] S_END   = 3'd4;

    logic [2:0]    state;
    logic          busy_r;
    logic          done_r;
    logic          crc_ok_r;
    logic          timeout_r;
    logic          err;
    logic [TW-1:0] tmo_cnt;
    logic [NW-1:0] nib_cnt;
    logic [3:0]    bit_cnt;
    logic [15:0]   crc_q [4];
    logic [3:0]    hi_nib;
    logic [7:0]    data_p0;
    logic          vld_p0;
    logic          arm_ok;
    logic          data_stb;
    logic          crc_mismatch;

    // One serial step of CRC16-CCITT (x^16 + x^12 + x^5 + 1), MSB first.
    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // Decode the events that several blocks react to.
    // An arm arriving in the done cycle is dropped, so the caller must
    // re-issue it after done.
    always_comb begin
        arm_ok       = (state == S_IDLE) && bus.arm && !done_r;
        data_stb     = (state == S_DATA) && bus.sample;
        crc_mismatch = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.sd_datIn[i] != crc_q[i][4'd15 - bit_cnt]) begin
                crc_mismatch = 1'b1;
            end
        end
    end

    // Block sequencer: start-bit search, payload, CRC trailer, end bit.
    always_ff @(posedge clk12mhz) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            crc_ok_r  <= 1'b0;
            timeout_r <= 1'b0;
            err       <= 1'b0;
            tmo_cnt   <= '0;
            nib_cnt   <= '0;
            bit_cnt   <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (arm_ok) begin
                        state     <= S_WAIT;
                        busy_r    <= 1'b1;
                        crc_ok_r  <= 1'b0;
                        timeout_r <= 1'b0;
                        err       <= 1'b0;
                        tmo_cnt   <= '0;
                    end
                end
                S_WAIT: begin
                    if (bus.sample) begin
                        // A start bit on the last allowed strobe still counts.
                        if (bus.sd_datIn == 4'b0000) begin
                            state   <= S_DATA;
                            nib_cnt <= '0;
                        end else if (tmo_cnt == TMO_LAST) begin
                            state     <= S_IDLE;
                            timeout_r <= 1'b1;
                            done_r    <= 1'b1;
                            busy_r    <= 1'b0;
                        end else begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (bus.sample) begin
                        if (nib_cnt == NIB_LAST) begin
                            state   <= S_CRC;
                            bit_cnt <= '0;
                        end else begin
                            nib_cnt <= nib_cnt + NW'(1);
                        end
                    end
                end
                S_CRC: begin
                    if (bus.sample) begin
                        if (crc_mismatch) begin
                            err <= 1'b1;
                        end
                        if (bit_cnt == 4'd15) begin
                            state <= S_END;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                S_END: begin
                    if (bus.sample) begin
                        state    <= S_IDLE;
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        crc_ok_r <= !(err || (bus.sd_datIn != 4'hF));
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Per-line CRC accumulators: cleared on an accepted arm and fed during payload.
    always_ff @(posedge clk12mhz) begin
        if (!rst_n || arm_ok) begin
            for (int i = 0; i < 4; i++) begin
                crc_q[i] <= '0;
            end
        end else if (data_stb) begin
            for (int i = 0; i < 4; i++) begin
                crc_q[i] <= crc16_step(crc_q[i], bus.sd_datIn[i]);
            end
        end
    end

    // Byte assembly. The high nibble is parked, and the byte is presented with
    // a one-cycle valid after its low nibble.
    always_ff @(posedge clk12mhz) begin
        if (data_stb && !nib_cnt[0]) begin
            hi_nib <= bus.sd_datIn;
        end
    end

    // Byte output register. Reset clears it, and it otherwise holds the last byte.
    always_ff @(posedge clk12mhz) begin
        if (!rst_n) begin
            data_p0 <= '0;
            vld_p0  <= 1'b0;
        end else begin
            vld_p0 <= 1'b0;
            if (data_stb && nib_cnt[0]) begin
                data_p0 <= {hi_nib, bus.sd_datIn};
                vld_p0  <= 1'b1;
            end
        end
    end

    assign bus.busy       = busy_r;
    assign bus.data       = data_p0;
    assign bus.data_valid = vld_p0;
    assign bus.done       = done_r;
    assign bus.crc_ok     = crc_ok_r;
    assign bus.timeout    = timeout_r;

endmodule

// File: tb/tb_sd_dat_block_rx.sv
// Bench for sd_dat_block_rx (BLOCK_BYTES=4, TIMEOUT_STROBES=8).
// The driver sends blocks strobe by strobe. For each block it records, keyed
// by clock cycle, what the outputs must show: the byte stream, the done pulse
// with its status, and the busy and status levels. Expected CRCs come from
// polynomial long division of each line's bit sequence.
module tb_sd_dat_block_rx;

    localparam int NB  = 4;
    localparam int TMO = 8;

    logic clk12mhz = 1'b0;
    logic rst_n    = 1'b0;
    int   cyc      = 0;
    int   total    = 0;
    int   bad      = 0;
    bit   chk_en   = 1'b0;

    logic [7:0] cur_blk [NB];
    logic [7:0] exp_dv   [int];
    logic [1:0] exp_done [int];
    logic       busy_chg [int];
    logic [1:0] stat_chg [int];
    logic       cur_busy = 1'b0;
    logic [1:0] cur_stat = 2'b00;

    sd_dat_block_rx_if bus();

    sd_dat_block_rx #(.BLOCK_BYTES(NB), .TIMEOUT_STROBES(TMO)) dut (
        .clk12mhz (clk12mhz),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    always #5 clk12mhz = ~clk12mhz;
    always @(posedge clk12mhz) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Remainder of msg(x) * x^16 divided by x^16 + x^12 + x^5 + 1.
    function automatic logic [15:0] crc_div(input bit msg[$]);
        bit          m[$];
        logic [16:0] g;
        logic [15:0] r;
        int          n;
        g = 17'h11021;
        m = msg;
        n = msg.size();
        repeat (16) m.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            if (m[i]) begin
                for (int j = 0; j < 17; j++) m[i+j] = m[i+j] ^ g[16-j];
            end
        end
        for (int k = 0; k < 16; k++) r[15-k] = m[n+k];
        return r;
    endfunction

    // Bit sequence that DAT line ln carries for cur_blk: bit ln of the high nibble, then of the low nibble, per byte.
    function automatic void get_line(input int ln, output bit q[$]);
        q = {};
        for (int b = 0; b < NB; b++) begin
            q.push_back(cur_blk[b][4+ln]);
            q.push_back(cur_blk[b][ln]);
        end
    endfunction

    // Per-cycle comparison against the recorded expectations.
    always @(negedge clk12mhz) begin
        if (chk_en) begin
            if (busy_chg.exists(cyc)) cur_busy = busy_chg[cyc];
            if (stat_chg.exists(cyc)) cur_stat = stat_chg[cyc];
            chk("busy", 32'(bus.busy), 32'(cur_busy));
            chk("crc_ok", 32'(bus.crc_ok), 32'(cur_stat[1]));
            chk("timeout", 32'(bus.timeout), 32'(cur_stat[0]));
            chk("data_valid", 32'(bus.data_valid), 32'(exp_dv.exists(cyc)));
            if (exp_dv.exists(cyc) && bus.data_valid) chk("data", 32'(bus.data), 32'(exp_dv[cyc]));
            chk("done", 32'(bus.done), 32'(exp_done.exists(cyc)));
        end
    end

    task automatic strobe(input logic [3:0] nib, input int gap);
        bus.sample   = 1'b1;
        bus.sd_datIn = nib;
        @(posedge clk12mhz); #1;
        bus.sample   = 1'b0;
        bus.sd_datIn = 4'($urandom);
        repeat (gap) begin
            @(posedge clk12mhz); #1;
        end
    endtask

    task automatic pulse_arm();
        bus.arm = 1'b1;
        @(posedge clk12mhz); #1;
        bus.arm = 1'b0;
    endtask

    task automatic do_arm();
        busy_chg[cyc+1] = 1'b1;
        stat_chg[cyc+1] = 2'b00;
        pulse_arm();
    endtask

    task automatic run_block(input int n_idle, input int gap, input int flip_line, input int flip_k,
                             input logic [3:0] end_nib, input bit arm_mid, input bit arm_in_done,
                             input int rst_after);
        logic [15:0] crc [4];
        logic [3:0]  nib;
        bit          q[$];
        bit          ok;
        for (int ln = 0; ln < 4; ln++) begin
            get_line(ln, q);
            crc[ln] = crc_div(q);
        end
        do_arm();
        repeat (n_idle) strobe(4'($urandom_range(1, 15)), gap);
        strobe(4'h0, gap);
        for (int b = 0; b < NB; b++) begin
            strobe(cur_blk[b][7:4], gap);
            exp_dv[cyc+1] = cur_blk[b];
            strobe(cur_blk[b][3:0], gap);
            if (arm_mid && b == 0) pulse_arm();
            if (rst_after == b + 1) begin
                rst_n = 1'b0;
                busy_chg[cyc+1] = 1'b0;
                stat_chg[cyc+1] = 2'b00;
                @(posedge clk12mhz); #1;
                rst_n = 1'b1;
                @(negedge clk12mhz);
                chk("rst_data", 32'(bus.data), 32'h0);
                chk("rst_busy", 32'(bus.busy), 32'h0);
                repeat (3) @(posedge clk12mhz);
                #1;
                return;
            end
        end
        for (int k = 0; k < 16; k++) begin
            for (int ln = 0; ln < 4; ln++) nib[ln] = crc[ln][15-k] ^ (ln == flip_line && k == flip_k);
            strobe(nib, gap);
        end
        ok = (flip_line < 0) && (end_nib == 4'hF);
        exp_done[cyc+1] = {ok, 1'b0};
        busy_chg[cyc+1] = 1'b0;
        stat_chg[cyc+1] = {ok, 1'b0};
        strobe(end_nib, 0);
        if (arm_in_done) pulse_arm();
        repeat (gap + 4) begin
            @(posedge clk12mhz); #1;
        end
    endtask

    task automatic run_timeout(input bit all_f);
        do_arm();
        for (int i = 1; i <= TMO; i++) begin
            if (i == TMO) begin
                exp_done[cyc+1] = 2'b01;
                busy_chg[cyc+1] = 1'b0;
                stat_chg[cyc+1] = 2'b01;
            end
            strobe(all_f ? 4'hF : 4'($urandom_range(1, 15)), 3);
        end
        repeat (4) begin
            @(posedge clk12mhz); #1;
        end
    endtask

    task automatic set_blk(input logic [31:0] v);
        for (int b = 0; b < NB; b++) cur_blk[b] = v[31-8*b -: 8];
    endtask

    initial begin
        bit          q[$];
        logic [7:0]  p;
        logic [71:0] s;
        int          gap;
        int          fl;
        logic [3:0]  en;

        bus.sample   = 1'b0;
        bus.arm      = 1'b0;
        bus.sd_datIn = 4'h0;

        // Literal pins on the model itself.
        s = "123456789";
        q = {};
        for (int i = 71; i >= 0; i--) q.push_back(s[i]);
        chk("pin_crc_check", 32'(crc_div(q)), 32'h31C3);
        q = {1'b1};
        chk("pin_crc_one", 32'(crc_div(q)), 32'h1021);
        set_blk(32'h1234ABCD);
        get_line(0, q);
        for (int i = 0; i < 8; i++) p[7-i] = q[i];
        chk("pin_line0", 32'(p), 32'hA5);
        get_line(3, q);
        for (int i = 0; i < 8; i++) p[7-i] = q[i];
        chk("pin_line3", 32'(p), 32'h0F);

        // Reset state.
        repeat (3) @(posedge clk12mhz);
        @(negedge clk12mhz);
        chk("reset_busy", 32'(bus.busy), 32'h0);
        chk("reset_data", 32'(bus.data), 32'h0);
        chk("reset_dv", 32'(bus.data_valid), 32'h0);
        chk("reset_done", 32'(bus.done), 32'h0);
        chk("reset_crc_ok", 32'(bus.crc_ok), 32'h0);
        chk("reset_timeout", 32'(bus.timeout), 32'h0);
        @(posedge clk12mhz); #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        repeat (2) begin
            @(posedge clk12mhz); #1;
        end

        set_blk(32'h1234ABCD);
        run_block(3, 3, -1, 0, 4'hF, 1'b0, 1'b0, -1);   // good block
        run_block(3, 3, 2, 5, 4'hF, 1'b0, 1'b0, -1);    // DAT2 CRC bit flipped
        run_block(3, 3, -1, 0, 4'hE, 1'b0, 1'b0, -1);   // bad end bit
        run_timeout(1'b1);                              // DAT held high
        run_block(3, 3, -1, 0, 4'hF, 1'b0, 1'b0, 2);    // reset mid payload
        run_block(3, 3, -1, 0, 4'hF, 1'b0, 1'b0, -1);   // recovery
        run_block(3, 3, -1, 0, 4'hF, 1'b1, 1'b1, -1);   // stray arms ignored
        run_block(TMO - 1, 2, -1, 0, 4'hF, 1'b0, 1'b0, -1); // start on last strobe
        set_blk(32'hFF00A55A);
        run_block(0, 0, -1, 0, 4'hF, 1'b0, 1'b0, -1);   // back-to-back strobes
        run_block(1, 0, 0, 15, 4'hF, 1'b0, 1'b0, -1);
        run_timeout(1'b0);

        for (int t = 0; t < 24; t++) begin
            set_blk($urandom);
            gap = $urandom_range(0, 4);
            fl  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            en  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
            run_block($urandom_range(0, TMO - 1), gap, fl, $urandom_range(0, 15), en,
                      1'($urandom), 1'($urandom), -1);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_dat_block_rx.md
Name: sd_dat_block_rx

Overview:
- Downstream of SDCardInitializer: once `done` and the RCA are available and a read command is issued, this block receives one data block on the 4-bit SD DAT bus.
- Samples `sd_datIn` on SD-clock rising-edge strobes, assembles bytes and streams them out.
- Checks the per-line CRC16 and the end bit, and reports completion, CRC error, or start-bit timeout.
- Runs entirely in the `clk12mhz` domain, using a one-cycle sample strobe from the SD clock generator.

Parameters:
- BLOCK_BYTES, 512, payload bytes per block; must be ≥1.
- TIMEOUT_STROBES, 65535, number of `sample` strobes to wait for the start bit before reporting timeout.

Ports:
- clk12mhz  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous reset, active low.
- sample  in  1  one-cycle strobe; `sd_datIn` is valid on this cycle (SD clock rising edge).
- arm  in  1  one-cycle request to begin waiting for a block.
- sd_datIn  in  4  SD DAT[3:0] input.
- busy  out  1  high from the accepted `arm` until the terminal pulse.
- data  out  8  received byte.
- data_valid  out  1  one-cycle pulse; `data` is valid this cycle.
- done  out  1  one-cycle pulse at block end, or on timeout.
- crc_ok  out  1  status for the last block; held until the next `arm`.
- timeout  out  1  status for the last block; held until the next `arm`.

Behaviour:
- Reset (`rst_n`=0 on a clock edge):
  - state=IDLE.
  - busy=0, data=0, data_valid=0, done=0, crc_ok=0, timeout=0.
  - Counters and CRC registers cleared.
  - Reset mid-block aborts with no `done` pulse.
- State machine: IDLE, WAIT_START, DATA, CRC, END.
  - State only advances on cycles with `sample`=1, except IDLE→WAIT_START, which happens on `arm`.
- IDLE:
  - `arm`=1 → WAIT_START next cycle.
  - busy=1, crc_ok=0, timeout=0, timeout counter=0, all four CRC regs=0.
- WAIT_START:
  - On `sample` with `sd_datIn`==4'b0000 → DATA, nibble counter=0.
  - Any other value → counter+1.
  - When the counter reaches TIMEOUT_STROBES without a start bit → IDLE, timeout=1, done pulse, busy=0.
  - A start bit on the same strobe that would hit the limit wins; no timeout.
- DATA:
  - Expects 2*BLOCK_BYTES nibble samples; the first nibble of each byte is bits [7:4].
  - Each line i feeds CRC register i with its bit: CRC16-CCITT, poly 0x1021, init 0, MSB-first, unreflected.
  - After the second nibble of a byte, data={hi,lo} and data_valid=1 on the following clk12mhz cycle, for exactly one cycle.
  - There is no backpressure; the consumer must accept every pulse.
  - After the last nibble → CRC, bit counter=0.
- CRC:
  - 16 samples; on each, line i's bit is compared with CRC register i bit [15-k], where k is the bit counter (MSB first).
  - Any mismatch sets a sticky error flag.
  - After 16 samples → END.
- END:
  - One sample; all four lines must read 1, otherwise the error flag is set.
  - Then → IDLE, done=1 for one cycle, busy=0, crc_ok = !error.
- Simultaneous events:
  - `arm` while busy is ignored.
  - `arm` in the same cycle as `done` is ignored; it must be re-issued after `done`.
  - `sample` on consecutive clk12mhz cycles is legal; the byte output still follows the rule above.
- Latency: the last data_valid precedes done by ≥17 sample strobes.
- Counter widths:
  - Nibble counter: clog2(2*BLOCK_BYTES) bits.
  - Timeout counter: clog2(TIMEOUT_STROBES+1) bits.
  - No wrap-around is reachable.

Test Plan:
- BLOCK_BYTES=4, sample every 4th cycle, arm, 3 idle strobes of 4'hF, start, bytes 0x12,0x34,0xAB,0xCD with correct CRCs, end=4'hF → four data_valid pulses in order, done once, crc_ok=1, timeout=0.
- Same stimulus with one CRC bit flipped on DAT2 → bytes still output, done pulse, crc_ok=0.
- Correct data and CRC but end nibble 4'hE → crc_ok=0.
- TIMEOUT_STROBES=8, arm, DAT held 4'hF → done on the 8th strobe, timeout=1, busy=0, no data_valid.
- rst_n low for one cycle mid-DATA → all outputs 0, state IDLE, no done. A re-arm and full block then succeeds with crc_ok=1.
- `arm` pulsed during DATA and in the `done` cycle → ignored, single block received, busy stays 0 afterwards.
